// File: rtl/mm_core.sv
// mm_core: one core of a row-striped multi-core matrix multiplier computing D = A x B over a shared data memory
// Ports: clock, reset (synchronous, active-high); start with dim_i/dim_j/dim_k and base_a/base_b/base_d job request;
//   busy, done status; write_en, addr_data, datain, dataout data-memory port (read data arrives one cycle after the address).
// Optional feature: define MM_CORE_SATURATE_EN for saturating accumulation instead of modulo wrap-around.
module mm_core #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 8,
  parameter int NUM_CORES = 4,
  parameter int CORE_ID   = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] dim_i,
  input  logic [ADDR_W-1:0] dim_j,
  input  logic [ADDR_W-1:0] dim_k,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_d,
  output logic              busy,
  output logic              done,
  output logic              write_en,
  output logic [ADDR_W-1:0] addr_data,
  output logic [DATA_W-1:0] datain,
  input  logic [DATA_W-1:0] dataout
);
  localparam int AW = ADDR_W + 8;
  localparam int IW = ADDR_W + 5;
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, MAC, STORE, FIN} state_t;
  state_t state;
  logic [ADDR_W-1:0] di, dj, dk, ba, bb, bd, j, k;
  logic [IW-1:0] i, i_next;
  logic [DATA_W-1:0] acc, a_reg, acc_next;
  // row-major element address, widened so intermediate products do not wrap before the final truncation
  function automatic logic [ADDR_W-1:0] lin(input logic [ADDR_W-1:0] b, input logic [IW-1:0] r,
                                            input logic [ADDR_W-1:0] n, input logic [ADDR_W-1:0] c);
    return ADDR_W'(AW'(b) + AW'(r) * AW'(n) + AW'(c));
  endfunction
  // i is kept wide enough that stepping past the last row never wraps back below dim_i
  assign i_next = i + IW'(NUM_CORES);
`ifdef MM_CORE_SATURATE_EN
  logic [2*DATA_W:0] sum;
  always_comb begin
    sum = (2*DATA_W+1)'(acc) + (2*DATA_W+1)'(a_reg) * (2*DATA_W+1)'(dataout);
    acc_next = |sum[2*DATA_W:DATA_W] ? '1 : sum[DATA_W-1:0];
  end
`else
  assign acc_next = acc + DATA_W'(a_reg * dataout);
`endif
  // outputs are registered: each transition loads the values the next state presents to memory
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      write_en <= 1'b0;
      addr_data <= '0;
      datain <= '0;
      acc <= '0;
      a_reg <= '0;
      i <= '0;
      j <= '0;
      k <= '0;
      di <= '0;
      dj <= '0;
      dk <= '0;
      ba <= '0;
      bb <= '0;
      bd <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          di <= dim_i;
          dj <= dim_j;
          dk <= dim_k;
          ba <= base_a;
          bb <= base_b;
          bd <= base_d;
          i <= IW'(CORE_ID);
          j <= '0;
          k <= '0;
          acc <= '0;
          if (dim_i == '0 || dim_j == '0 || dim_k == '0 || IW'(CORE_ID) >= IW'(dim_i)) begin
            state <= FIN;
            done <= 1'b1;
          end else begin
            state <= RD_A;
            busy <= 1'b1;
            addr_data <= lin(base_a, IW'(CORE_ID), dim_k, '0);
          end
        end
        RD_A: begin
          state <= RD_B;
          addr_data <= lin(bb, IW'(k), dj, j);
        end
        RD_B: begin
          a_reg <= dataout;
          state <= MAC;
        end
        MAC: begin
          acc <= acc_next;
          if (k == dk - 1'b1) begin
            state <= STORE;
            write_en <= 1'b1;
            datain <= acc_next;
            addr_data <= lin(bd, i, dj, j);
          end else begin
            k <= k + 1'b1;
            state <= RD_A;
            addr_data <= lin(ba, i, dk, k + 1'b1);
          end
        end
        STORE: begin
          write_en <= 1'b0;
          datain <= '0;
          acc <= '0;
          k <= '0;
          if (j < dj - 1'b1) begin
            j <= j + 1'b1;
            state <= RD_A;
            addr_data <= lin(ba, i, dk, '0);
          end else begin
            j <= '0;
            i <= i_next;
            if (i_next < IW'(di)) begin
              state <= RD_A;
              addr_data <= lin(ba, i_next, dk, '0);
            end else begin
              state <= FIN;
              busy <= 1'b0;
              done <= 1'b1;
              addr_data <= '0;
            end
          end
        end
        FIN: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mm_core.sv
// tb_mm_core: scoreboard bench for mm_core with two instances (single core, and core 1 of 2)
module tb_mm_core;
  logic clock = 1'b0, reset = 1'b1, start0 = 1'b0, start1 = 1'b0;
  logic [7:0] dim_i = '0, dim_j = '0, dim_k = '0, base_a = '0, base_b = '0, base_d = '0;
  logic busy0, done0, we0, busy1, done1, we1;
  logic [7:0] ad0, ad1;
  logic [15:0] di0, di1, do0, do1;
  logic [15:0] mem0 [256];
  logic [15:0] mem1 [256];
  int vec = 0, bad = 0, gc = 0, ts0 = 0, ts1 = 0, dn0 = 0, dn1 = 0;
  logic [23:0] wq0 [$], wq1 [$];
  int dq0 [$], dq1 [$];
`ifdef MM_CORE_SATURATE_EN
  localparam logic [15:0] OVF = 16'hFFFF;
`else
  localparam logic [15:0] OVF = 16'hFFFE;
`endif

  always #5 clock = ~clock;

  mm_core #(.NUM_CORES(1), .CORE_ID(0)) u0 (
    .clock(clock), .reset(reset), .start(start0), .dim_i(dim_i), .dim_j(dim_j), .dim_k(dim_k),
    .base_a(base_a), .base_b(base_b), .base_d(base_d), .busy(busy0), .done(done0),
    .write_en(we0), .addr_data(ad0), .datain(di0), .dataout(do0));
  mm_core #(.NUM_CORES(2), .CORE_ID(1)) u1 (
    .clock(clock), .reset(reset), .start(start1), .dim_i(dim_i), .dim_j(dim_j), .dim_k(dim_k),
    .base_a(base_a), .base_b(base_b), .base_d(base_d), .busy(busy1), .done(done1),
    .write_en(we1), .addr_data(ad1), .datain(di1), .dataout(do1));

  always @(posedge clock) begin
    gc <= gc + 1;
    do0 <= mem0[ad0];
    do1 <= mem1[ad1];
    if (we0) mem0[ad0] <= di0;
    if (we1) mem1[ad1] <= di1;
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vec++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask

  always @(negedge clock) begin
    if (we0) begin
      chk("write0_queued", 32'(wq0.size() > 0), 1);
      if (wq0.size() > 0) chk("write0_addr_data", {ad0, di0}, wq0.pop_front());
    end
    if (done0) begin
      dn0++;
      chk("done0_queued", 32'(dq0.size() > 0), 1);
      if (dq0.size() > 0) chk("done0_cycle", gc - ts0, dq0.pop_front());
    end
    if (we1) begin
      chk("write1_queued", 32'(wq1.size() > 0), 1);
      if (wq1.size() > 0) chk("write1_addr_data", {ad1, di1}, wq1.pop_front());
    end
    if (done1) begin
      dn1++;
      chk("done1_queued", 32'(dq1.size() > 0), 1);
      if (dq1.size() > 0) chk("done1_cycle", gc - ts1, dq1.pop_front());
    end
  end

  task automatic job(input bit c, input logic [7:0] i_, j_, k_, a_, b_, d_);
    @(negedge clock);
    {dim_i, dim_j, dim_k, base_a, base_b, base_d} = {i_, j_, k_, a_, b_, d_};
    if (c) begin start1 = 1'b1; ts1 = gc; end
    else begin start0 = 1'b1; ts0 = gc; end
    @(negedge clock);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input bit c, input int budget);
    int s;
    s = c ? dn1 : dn0;
    for (int n = 0; n < budget; n++) begin
      @(posedge clock);
      if ((c ? dn1 : dn0) != s) break;
    end
    chk("done_within_budget", 32'((c ? dn1 : dn0) != s), 1);
    @(negedge clock);
  endtask

  initial begin
    int d;
    for (int n = 0; n < 256; n++) begin mem0[n] = '0; mem1[n] = '0; end
    {mem0[8'h00], mem0[8'h01], mem0[8'h02], mem0[8'h03]} = {16'd1, 16'd2, 16'd3, 16'd4};
    {mem0[8'h10], mem0[8'h11], mem0[8'h12], mem0[8'h13]} = {16'd1, 16'd0, 16'd0, 16'd1};
    {mem0[8'h40], mem0[8'h41]} = {16'hFFFF, 16'h0002};
    {mem0[8'h50], mem0[8'h51], mem0[8'h52]} = {16'd1, 16'd2, 16'd3};
    {mem0[8'h60], mem0[8'h61], mem0[8'h62], mem0[8'h63], mem0[8'h64], mem0[8'h65]} =
      {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
    {mem1[8'h00], mem1[8'h01], mem1[8'h02], mem1[8'h10]} = {16'd5, 16'd6, 16'd7, 16'd2};
    repeat (3) @(negedge clock);
    chk("reset_busy", busy0, 0);
    chk("reset_done", done0, 0);
    chk("reset_write_en", we0, 0);
    chk("reset_addr", ad0, 0);
    chk("reset_datain", di0, 0);
    reset = 1'b0;
    // 2x2 times identity
    wq0.push_back({8'h20, 16'd1}); wq0.push_back({8'h21, 16'd2});
    wq0.push_back({8'h22, 16'd3}); wq0.push_back({8'h23, 16'd4});
    dq0.push_back(29);
    job(0, 2, 2, 2, 8'h00, 8'h10, 8'h20);
    wait_done(0, 100);
    // 1x3 times 3x2
    wq0.push_back({8'h70, 16'd22}); wq0.push_back({8'h71, 16'd28});
    dq0.push_back(21);
    job(0, 1, 2, 3, 8'h50, 8'h60, 8'h70);
    wait_done(0, 100);
    // accumulator overflow
    wq0.push_back({8'h42, OVF});
    dq0.push_back(5);
    job(0, 1, 1, 1, 8'h40, 8'h41, 8'h42);
    wait_done(0, 100);
    // row striding: core 1 of 2 owns only row 1
    wq1.push_back({8'h21, 16'd12});
    dq1.push_back(5);
    job(1, 3, 1, 1, 8'h00, 8'h10, 8'h20);
    wait_done(1, 100);
    // zero inner dimension
    dq0.push_back(1);
    job(0, 2, 2, 0, 8'h00, 8'h10, 8'h20);
    chk("zero_dim_busy", busy0, 0);
    chk("zero_dim_done", done0, 1);
    @(negedge clock);
    chk("zero_dim_done_pulse", done0, 0);
    chk("zero_dim_busy_after", busy0, 0);
    // reset during MAC aborts with no write and no done
    d = dn0;
    job(0, 2, 2, 2, 8'h00, 8'h10, 8'h20);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_busy", busy0, 0);
    chk("abort_done", done0, 0);
    chk("abort_write_en", we0, 0);
    chk("abort_addr", ad0, 0);
    chk("abort_datain", di0, 0);
    repeat (40) @(negedge clock);
    chk("abort_no_done", dn0 - d, 0);
    // start pulsed while busy, with different inputs, must be ignored
    d = dn0;
    wq0.push_back({8'h30, 16'd1}); wq0.push_back({8'h31, 16'd2});
    wq0.push_back({8'h32, 16'd3}); wq0.push_back({8'h33, 16'd4});
    dq0.push_back(29);
    job(0, 2, 2, 2, 8'h00, 8'h10, 8'h30);
    repeat (5) @(negedge clock);
    {dim_i, dim_j, dim_k, base_a, base_b, base_d} = {8'd1, 8'd1, 8'd1, 8'h40, 8'h41, 8'h42};
    start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    wait_done(0, 100);
    repeat (10) @(negedge clock);
    chk("done_count_busy_start", dn0 - d, 1);
    chk("scoreboard_drained", wq0.size() + wq1.size() + dq0.size() + dq1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule

// File: doc/mm_core.md
MM_CORE -- requirements
Module: mm_core

Interface
REQ-001 Parameter DATA_W, default 16, element/accumulator width in bits.
REQ-002 Parameter ADDR_W, default 8, data-memory address width; also width of the dim_* and base_* ports.
REQ-003 Parameter NUM_CORES, default 4, cores sharing one matrix job, range 1..16.
REQ-004 Parameter CORE_ID, default 0, this core's row offset, range 0..NUM_CORES-1.
REQ-005 clock  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle job request; sampled only in IDLE.
REQ-008 dim_i, dim_j, dim_k  in  ADDR_W each  C = A(dim_i x dim_k) x B(dim_k x dim_j); sampled with start.
REQ-009 base_a, base_b, base_d  in  ADDR_W each  row-major base addresses of A, B, D; sampled with start.
REQ-010 busy  out  1  high while the job runs.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 write_en  out  1  data-memory write strobe.
REQ-013 addr_data  out  ADDR_W  data-memory address.
REQ-014 datain  out  DATA_W  write data to memory.
REQ-015 dataout  in  DATA_W  read data from memory; valid the cycle after the address is presented with write_en=0.

Function
REQ-016 FSM states: IDLE, RD_A, RD_B, MAC, STORE, FIN.
REQ-017 IDLE: start=1 latches dims/bases, sets i=CORE_ID, j=0, k=0, acc=0 and moves to RD_A; if dim_i, dim_j or dim_k is 0, or CORE_ID>=dim_i, moves directly to FIN.
REQ-018 RD_A: addr_data=base_a+i*dim_k+k, write_en=0 -> RD_B.
REQ-019 RD_B: latches dataout as a_reg; addr_data=base_b+k*dim_j+j, write_en=0 -> MAC.
REQ-020 MAC: acc=acc+a_reg*dataout, product and sum truncated to DATA_W (unsigned); if k==dim_k-1 -> STORE, else k+=1 -> RD_A.
REQ-021 STORE: write_en=1, addr_data=base_d+i*dim_j+j, datain=acc; clears acc and k.
REQ-022 STORE next state: if j<dim_j-1 then j+=1 and go to RD_A; else j=0, i+=NUM_CORES, and go to RD_A if the new i<dim_i, otherwise FIN.
REQ-023 FIN: done=1 for exactly one cycle -> IDLE.
REQ-024 All address arithmetic is computed at ADDR_W+8 bits and truncated to ADDR_W (wrap-around, no error).
REQ-025 i is compared at ADDR_W+5 bits so that i+NUM_CORES never wraps below dim_i.
REQ-026 busy=1 in RD_A, RD_B, MAC and STORE; 0 in IDLE and FIN.
REQ-027 Latency: done is high exactly R*dim_j*(3*dim_k+1)+1 cycles after the start edge, where R = count of i in {CORE_ID, CORE_ID+NUM_CORES, ...} with i<dim_i.
REQ-028 start while not in IDLE is ignored; changes to dim/base inputs mid-job have no effect.
REQ-029 Outside STORE, write_en=0 and datain=0; in IDLE and FIN, addr_data=0.

Reset
REQ-030 reset=1 at a clock edge forces IDLE and sets busy, done, write_en, addr_data, datain, acc, i, j, k and a_reg to 0, in any state.
REQ-031 Reset mid-job aborts without done and without any further write; reset has priority over start in the same cycle.

Configuration
REQ-032 Macro MM_CORE_SATURATE_EN, when defined, replaces wrap-around accumulation in MAC with unsigned saturation at 2^DATA_W-1 (acc stays at that value for the rest of the element).
REQ-033 Without MM_CORE_SATURATE_EN, accumulation wraps modulo 2^DATA_W.
REQ-034 Address arithmetic wraps regardless of the macro.

Verification
REQ-035 2x2 test: NUM_CORES=1; A=[1,2;3,4] at 0x00, B=identity at 0x10, D at 0x20, start -> D=[1,2;3,4], done at cycle 4*7+1=29, exactly 4 writes.
REQ-036 Striding test: NUM_CORES=2, CORE_ID=1, dim_i=3, dim_j=dim_k=1, A=[5,6,7], B=[2] -> single write of 12 to base_d+1, done at cycle 5.
REQ-037 Overflow test: dim=1x1x1, A=0xFFFF, B=0x0002 -> D=0xFFFE without the macro, 0xFFFF with MM_CORE_SATURATE_EN.
REQ-038 Zero-dimension test: dim_k=0, start -> no write_en, busy stays 0, done pulses 1 cycle after start.
REQ-039 Reset/start test: assert reset for 1 cycle in the MAC state of a 2x2 job -> all outputs 0 on the next cycle, no done, no write; start pulsed while busy -> ignored, done count stays 1.
